csm_dual_port_responder: RTL

- Responder end of the CSM processor protocol: serves two processor ports, A and B, against one shared byte memory.
- Each port drives a multiplexed address/data bus (in_AD) plus rw/enable/hold/release. The block decodes each transaction, enforces per-address hold locks, performs the access, and returns ack/err/out_data.
- Sits between the processor-side stimulus (tester/bfm) and storage; it is the DUT-side counterpart of the CSM bfm signal set.

---
 rtl/csm_dual_port_responder.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/csm_dual_port_responder.sv
// CSM protocol responder: two processor ports sharing one byte memory, with per-port hold locks.
// Optional build macro CSM_LOCK_TIMEOUT_EN adds idle-lock expiry after LOCK_TIMEOUT cycles.
module csm_dual_port_responder #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned LOCK_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] A_in_AD,
    input  logic              A_rw,
    input  logic              A_enable,
    input  logic              A_hold,
    input  logic              A_release,
    output logic              A_ack,
    output logic [1:0]        A_err,
    output logic [DATA_W-1:0] A_out_data,
    input  logic [DATA_W-1:0] B_in_AD,
    input  logic              B_rw,
    input  logic              B_enable,
    input  logic              B_hold,
    input  logic              B_release,
    output logic              B_ack,
    output logic [1:0]        B_err,
    output logic [DATA_W-1:0] B_out_data
);

    typedef enum logic [1:0] {StIdle, StData, StAcc, StResp} state_e;

    logic [DATA_W-1:0] in_ad [2];
    logic              en [2], rw [2], hold [2], rel [2];

    state_e            state_q [2], state_d [2];
    logic [ADDR_W-1:0] addr_q [2], addr_d [2];
    logic              rw_q [2], rw_d [2], hold_q [2], hold_d [2], rel_q [2], rel_d [2];
    logic [DATA_W-1:0] wdata_q [2], wdata_d [2];
    logic [1:0]        err_q [2], err_d [2];
    logic [DATA_W-1:0] out_q [2], out_d [2];
    logic              lock_vld_q [2], lock_vld_d [2];
    logic [ADDR_W-1:0] lock_addr_q [2], lock_addr_d [2];

    logic [1:0]        acc_err [2];
    logic              other_lock [2], own_hit [2], conflict [2], lost [2];
    logic              we [2];

    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign in_ad[0] = A_in_AD;
    assign en[0]    = A_enable;
    assign rw[0]    = A_rw;
    assign hold[0]  = A_hold;
    assign rel[0]   = A_release;
    assign in_ad[1] = B_in_AD;
    assign en[1]    = B_enable;
    assign rw[1]    = B_rw;
    assign hold[1]  = B_hold;
    assign rel[1]   = B_release;

    // Lock check; A wins same-address write/write or hold/hold collisions.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            other_lock[p[0]] = lock_vld_q[~p[0]] && (lock_addr_q[~p[0]] == addr_q[p[0]]);
            own_hit[p[0]]    = lock_vld_q[p[0]] && (lock_addr_q[p[0]] == addr_q[p[0]]);
            conflict[p[0]]   = hold_q[p[0]] &&
                               ((lock_vld_q[p[0]] && !own_hit[p[0]]) || rel_q[p[0]]);
        end
        lost[0] = 1'b0;
        lost[1] = (state_q[0] == StAcc) && (state_q[1] == StAcc) &&
                  (addr_q[0] == addr_q[1]) && !other_lock[0] &&
                  ((rw_q[0] && rw_q[1]) || (hold_q[0] && hold_q[1]));
        for (int p = 0; p < 2; p++) begin
            if (other_lock[p[0]]) begin
                acc_err[p[0]] = 2'b01;
            end else if (conflict[p[0]] || lost[p[0]]) begin
                acc_err[p[0]] = 2'b10;
            end else if (rel_q[p[0]] && !own_hit[p[0]]) begin
                acc_err[p[0]] = 2'b11;
            end else begin
                acc_err[p[0]] = 2'b00;
            end
        end
    end

`ifdef CSM_LOCK_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(LOCK_TIMEOUT + 1);
    logic [CntW-1:0] cnt_q [2], cnt_d [2];
`else
    logic unused_lock_timeout;
    assign unused_lock_timeout = ^LOCK_TIMEOUT;
`endif

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            state_d[p[0]]     = state_q[p[0]];
            addr_d[p[0]]      = addr_q[p[0]];
            rw_d[p[0]]        = rw_q[p[0]];
            hold_d[p[0]]      = hold_q[p[0]];
            rel_d[p[0]]       = rel_q[p[0]];
            wdata_d[p[0]]     = wdata_q[p[0]];
            err_d[p[0]]       = err_q[p[0]];
            out_d[p[0]]       = out_q[p[0]];
            lock_vld_d[p[0]]  = lock_vld_q[p[0]];
            lock_addr_d[p[0]] = lock_addr_q[p[0]];
            we[p[0]]          = 1'b0;
`ifdef CSM_LOCK_TIMEOUT_EN
            // Any activity by the owner restarts the idle count.
            cnt_d[p[0]] = '0;
            if (state_q[p[0]] == StIdle && lock_vld_q[p[0]]) begin
                if (cnt_q[p[0]] + 1'b1 == CntW'(LOCK_TIMEOUT)) begin
                    lock_vld_d[p[0]] = 1'b0;
                end else begin
                    cnt_d[p[0]] = cnt_q[p[0]] + 1'b1;
                end
            end
`endif
            unique case (state_q[p[0]])
                StIdle: begin
                    if (en[p[0]]) begin
                        addr_d[p[0]]  = in_ad[p[0]][ADDR_W-1:0];
                        rw_d[p[0]]    = rw[p[0]];
                        hold_d[p[0]]  = hold[p[0]];
                        rel_d[p[0]]   = rel[p[0]];
                        state_d[p[0]] = rw[p[0]] ? StData : StAcc;
                    end
                end
                StData: begin
                    wdata_d[p[0]] = in_ad[p[0]];
                    state_d[p[0]] = StAcc;
                end
                StAcc: begin
                    err_d[p[0]] = acc_err[p[0]];
                    out_d[p[0]] = '0;
                    if (acc_err[p[0]] != 2'b01 && !lost[p[0]]) begin
                        we[p[0]] = rw_q[p[0]];
                        if (!rw_q[p[0]]) begin
                            out_d[p[0]] = mem[addr_q[p[0]]];
                        end
                    end
                    if (acc_err[p[0]] == 2'b00) begin
                        if (hold_q[p[0]]) begin
                            lock_vld_d[p[0]]  = 1'b1;
                            lock_addr_d[p[0]] = addr_q[p[0]];
                        end else if (rel_q[p[0]]) begin
                            lock_vld_d[p[0]] = 1'b0;
                        end
                    end
                    state_d[p[0]] = StResp;
                end
                StResp: state_d[p[0]] = StIdle;
                default: state_d[p[0]] = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                state_q[p[0]]     <= StIdle;
                addr_q[p[0]]      <= '0;
                rw_q[p[0]]        <= 1'b0;
                hold_q[p[0]]      <= 1'b0;
                rel_q[p[0]]       <= 1'b0;
                wdata_q[p[0]]     <= '0;
                err_q[p[0]]       <= 2'b00;
                out_q[p[0]]       <= '0;
                lock_vld_q[p[0]]  <= 1'b0;
                lock_addr_q[p[0]] <= '0;
`ifdef CSM_LOCK_TIMEOUT_EN
                cnt_q[p[0]]       <= '0;
`endif
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                state_q[p[0]]     <= state_d[p[0]];
                addr_q[p[0]]      <= addr_d[p[0]];
                rw_q[p[0]]        <= rw_d[p[0]];
                hold_q[p[0]]      <= hold_d[p[0]];
                rel_q[p[0]]       <= rel_d[p[0]];
                wdata_q[p[0]]     <= wdata_d[p[0]];
                err_q[p[0]]       <= err_d[p[0]];
                out_q[p[0]]       <= out_d[p[0]];
                lock_vld_q[p[0]]  <= lock_vld_d[p[0]];
                lock_addr_q[p[0]] <= lock_addr_d[p[0]];
`ifdef CSM_LOCK_TIMEOUT_EN
                cnt_q[p[0]]       <= cnt_d[p[0]];
`endif
            end
        end
    end

    // B is written first so A's data lands if both ever target one address.
    always_ff @(posedge clk) begin
        if (we[1]) mem[addr_q[1]] <= wdata_q[1];
        if (we[0]) mem[addr_q[0]] <= wdata_q[0];
    end

    assign A_ack      = (state_q[0] == StResp);
    assign A_err      = A_ack ? err_q[0] : 2'b00;
    assign A_out_data = out_q[0];
    assign B_ack      = (state_q[1] == StResp);
    assign B_err      = B_ack ? err_q[1] : 2'b00;
    assign B_out_data = out_q[1];

endmodule
